alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: 8-entry register file, operand latch towards an external
// combinational ALU, fixed-length execute wait, then result commit and flag update.
module alu_operand_stage #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_fs,
   input  logic             in_cin,
   input  logic [2:0]       in_ra,
   input  logic [2:0]       in_rb,
   input  logic [2:0]       in_rd,
   input  logic             in_use_imm,
   input  logic [WIDTH-1:0] in_imm,
   input  logic             in_we,
   output logic [4:0]       alu_fs,
   output logic             alu_cin,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_f,
   input  logic             alu_cout,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   input  logic [2:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("alu_operand_stage: EXEC_CYCLES must be in 1..15");
   end

   localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e           r_state;
   logic [3:0]       r_cnt;
   // Entry 0 is reset to zero and never written, so it always reads as zero.
   logic [WIDTH-1:0] r_regs [8];
   logic [2:0]       r_rd;
   logic             r_we;
   logic [4:0]       r_alu_fs;
   logic             r_alu_cin;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_valid;
   logic             r_flag_z;
   logic             r_flag_n;
   logic             r_flag_c;

   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;

   assign w_op_a    = r_regs[in_ra];
   assign w_op_b    = in_use_imm ? in_imm : r_regs[in_rb];
   assign dbg_data  = r_regs[dbg_addr];
   assign in_ready  = (r_state == StIdle);
   assign alu_fs    = r_alu_fs;
   assign alu_cin   = r_alu_cin;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign flag_z    = r_flag_z;
   assign flag_n    = r_flag_n;
   assign flag_c    = r_flag_c;

   // Control FSM with latched operands, result capture, commit and register file write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= '0;
         end
         r_rd        <= 3'd0;
         r_we        <= 1'b0;
         r_alu_fs    <= 5'd0;
         r_alu_cin   <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_flag_z    <= 1'b0;
         r_flag_n    <= 1'b0;
         r_flag_c    <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_alu_a   <= w_op_a;
                  r_alu_b   <= w_op_b;
                  r_alu_fs  <= in_fs;
                  r_alu_cin <= in_cin;
                  r_rd      <= in_rd;
                  r_we      <= in_we;
                  r_cnt     <= CntInit;
                  r_state   <= StExec;
               end
            end
            StExec: begin
               // ALU outputs have been stable for EXEC_CYCLES cycles when the count hits zero.
               if (r_cnt == 4'd0) begin
                  r_result <= alu_f;
                  r_cout   <= alu_cout;
                  r_state  <= StWb;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            StWb: begin
               if (r_we && (r_rd != 3'd0)) begin
                  r_regs[r_rd] <= r_result;
               end
               r_res_data  <= r_result;
               r_res_valid <= 1'b1;
               r_flag_z    <= (r_result == '0);
               r_flag_n    <= r_result[WIDTH-1];
               r_flag_c    <= r_cout;
               r_state     <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
